// File: rtl/core_seq_ctrl_pkg.sv
// Shared types for the core sequencer: opcodes, controller states, next-PC helper.
package core_seq_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_I_TYPE = 7'b0010011,
    OP_R_TYPE = 7'b0110011
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } ctrl_state_t;

  function automatic logic op_known(logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_I_TYPE, OP_R_TYPE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // JALR clears target bit 0; misalignment (bit 1) is judged by the caller.
  function automatic logic [DATA_WIDTH-1:0] calc_next_pc(
    opcode_t op, logic taken, logic [DATA_WIDTH-1:0] tgt, logic [DATA_WIDTH-1:0] pc);
    logic [DATA_WIDTH-1:0] npc;
    npc = pc + 32'd4;
    if (op == OP_JAL || (op == OP_BRANCH && taken)) npc = tgt;
    else if (op == OP_JALR) npc = {tgt[DATA_WIDTH-1:1], 1'b0};
    return npc;
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Handshake bundle between the sequencer and imem / decoder / ALU / dmem.
interface core_seq_ctrl_if;
  import core_seq_ctrl_pkg::*;

  logic [DATA_WIDTH-1:0] pc;
  logic                  imem_req_valid;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [DATA_WIDTH-1:0] instr;
  logic                  dec_req_valid;
  logic                  dec_resp_valid;
  logic [6:0]            dec_opcode;
  logic                  alu_req_valid;
  logic                  alu_resp_valid;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] target_addr;
  logic                  dmem_req_valid;
  logic                  dmem_we;
  logic                  dmem_resp_valid;
  logic                  rf_we;
  logic                  trap;
  logic [DATA_WIDTH-1:0] retired;

  modport master (
    output pc, imem_req_valid, instr, dec_req_valid, alu_req_valid,
           dmem_req_valid, dmem_we, rf_we, trap, retired,
    input  imem_resp_valid, imem_rdata, dec_resp_valid, dec_opcode,
           alu_resp_valid, branch_taken, target_addr, dmem_resp_valid
  );

  modport slave (
    input  pc, imem_req_valid, instr, dec_req_valid, alu_req_valid,
           dmem_req_valid, dmem_we, rf_we, trap, retired,
    output imem_resp_valid, imem_rdata, dec_resp_valid, dec_opcode,
           alu_resp_valid, branch_taken, target_addr, dmem_resp_valid
  );

endinterface

// File: rtl/core_seq_ctrl_timeout.sv
// Request watchdog: counts cycles with a request outstanding, cleared on state entry.
module core_seq_timeout #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1) + 1;

  logic [CW-1:0] cnt;

  // LIMIT of 0 disables the watchdog entirely.
  assign expired = (LIMIT != 0) && (cnt >= CW'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (busy && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: owns PC/IR and walks each instruction through
// fetch/decode/execute/memory/writeback via req/resp handshakes.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC       = 32'h0000_0000,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  core_seq_ctrl_if.master bus
);

  ctrl_state_t           state, prev_state;
  opcode_t               op_q;
  logic                  taken_q;
  logic [DATA_WIDTH-1:0] tgt_q;
  logic [DATA_WIDTH-1:0] npc;
  logic                  complete, dec_bad, go_trap;
  logic                  tmo_clr, tmo_busy, tmo_expired, tmo_hit;

  assign tmo_clr  = (state != prev_state);
  assign tmo_busy = bus.imem_req_valid | bus.dec_req_valid |
                    bus.alu_req_valid  | bus.dmem_req_valid;
  // The counter still holds the previous state's count on the entry cycle.
  assign tmo_hit  = tmo_expired && !tmo_clr;

  core_seq_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .busy    (tmo_busy),
    .expired (tmo_expired)
  );

  // A branch completes in the ALU response cycle, so use the live compare there.
  always_comb begin
    npc = calc_next_pc(op_q, taken_q, tgt_q, bus.pc);
    if (state == S_EXEC) npc = calc_next_pc(op_q, bus.branch_taken, bus.target_addr, bus.pc);
  end

  assign complete = (state == S_EXEC && bus.alu_req_valid && bus.alu_resp_valid && op_q == OP_BRANCH) ||
                    (state == S_MEM  && bus.dmem_req_valid && bus.dmem_resp_valid && op_q == OP_STORE) ||
                    (state == S_WB);
  assign dec_bad  = state == S_DECODE && bus.dec_req_valid && bus.dec_resp_valid &&
                    !op_known(bus.dec_opcode);
  assign go_trap  = (state != S_TRAP) && (tmo_hit || dec_bad || (complete && npc[1]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_FETCH;
      prev_state         <= S_FETCH;
      bus.pc             <= RESET_PC;
      bus.instr          <= '0;
      bus.retired        <= '0;
      bus.trap           <= 1'b0;
      bus.imem_req_valid <= 1'b0;
      bus.dec_req_valid  <= 1'b0;
      bus.alu_req_valid  <= 1'b0;
      bus.dmem_req_valid <= 1'b0;
      bus.dmem_we        <= 1'b0;
      bus.rf_we          <= 1'b0;
      op_q               <= OP_R_TYPE;
      taken_q            <= 1'b0;
      tgt_q              <= '0;
    end else begin
      prev_state <= state;
      bus.rf_we  <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!bus.imem_req_valid) bus.imem_req_valid <= 1'b1;
          if (bus.imem_req_valid && bus.imem_resp_valid) begin
            bus.imem_req_valid <= 1'b0;
            bus.instr          <= bus.imem_rdata;
            bus.dec_req_valid  <= 1'b1;
            state              <= S_DECODE;
          end
        end
        S_DECODE: if (bus.dec_req_valid && bus.dec_resp_valid) begin
          bus.dec_req_valid <= 1'b0;
          op_q              <= opcode_t'(bus.dec_opcode);
          if (bus.dec_opcode == OP_LUI) begin
            bus.rf_we <= 1'b1;
            state     <= S_WB;
          end else begin
            bus.alu_req_valid <= 1'b1;
            state             <= S_EXEC;
          end
        end
        S_EXEC: if (bus.alu_req_valid && bus.alu_resp_valid) begin
          bus.alu_req_valid <= 1'b0;
          taken_q           <= bus.branch_taken;
          tgt_q             <= bus.target_addr;
          if (op_q == OP_LOAD || op_q == OP_STORE) begin
            bus.dmem_req_valid <= 1'b1;
            bus.dmem_we        <= (op_q == OP_STORE);
            state              <= S_MEM;
          end else if (op_q != OP_BRANCH) begin
            bus.rf_we <= 1'b1;
            state     <= S_WB;
          end
        end
        S_MEM: if (bus.dmem_req_valid && bus.dmem_resp_valid) begin
          bus.dmem_req_valid <= 1'b0;
          bus.dmem_we        <= 1'b0;
          if (op_q == OP_LOAD) begin
            bus.rf_we <= 1'b1;
            state     <= S_WB;
          end
        end
        S_WB:    ;
        S_TRAP:  ;
        default: begin
          state    <= S_TRAP;
          bus.trap <= 1'b1;
        end
      endcase

      if (complete && !npc[1]) begin
        bus.pc             <= npc;
        bus.retired        <= bus.retired + 32'd1;
        bus.imem_req_valid <= 1'b1;
        state              <= S_FETCH;
      end

      // Trap wins over any transition made above in the same cycle.
      if (go_trap) begin
        state              <= S_TRAP;
        bus.trap           <= 1'b1;
        bus.imem_req_valid <= 1'b0;
        bus.dec_req_valid  <= 1'b0;
        bus.alu_req_valid  <= 1'b0;
        bus.dmem_req_valid <= 1'b0;
        bus.dmem_we        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: delay-programmable responders, vector table with scoreboard,
// and hand-written sequences for decoder stall, fetch timeout and mid-fetch reset.
module tb_core_seq_ctrl;
  import core_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_seq_ctrl_if bus();

  core_seq_ctrl #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc, instr, tgt;
    logic        tk;
    logic [31:0] exp_pc, exp_ret;
    int          exp_rf, exp_dreq;
    logic        exp_dwe, exp_trap;
  } vec_t;

  logic [31:0] mem [128];
  logic        tk_mem [128];
  logic [31:0] tg_mem [128];

  int   dly [4];
  int   cnt [4];
  bit   done [4];
  logic [3:0] rsp = '0;
  logic [3:0] rq;
  logic [3:0] prq = '0;
  int   rf_cnt = 0, dreq_cnt = 0, dwe_cnt = 0, dec_req_cnt = 0, hs_viol = 0;

  int total = 0, bad = 0;
  vec_t vt [8];
  vec_t sbq [$];

  assign rq = {bus.dmem_req_valid, bus.alu_req_valid, bus.dec_req_valid, bus.imem_req_valid};
  assign bus.imem_resp_valid = rsp[0];
  assign bus.dec_resp_valid  = rsp[1];
  assign bus.alu_resp_valid  = rsp[2];
  assign bus.dmem_resp_valid = rsp[3];
  assign bus.imem_rdata      = mem[bus.pc[8:2]];
  assign bus.dec_opcode      = bus.instr[6:0];
  assign bus.branch_taken    = tk_mem[bus.pc[8:2]];
  assign bus.target_addr     = tg_mem[bus.pc[8:2]];

  // Responders and monitors share one block so prior-cycle resp values are unambiguous.
  always @(negedge clk) begin
    if (!rst && !bus.trap) begin
      if (prq[1] && rsp[1] && bus.dec_req_valid) hs_viol++;
      if (prq[1] && !rsp[1] && !bus.dec_req_valid) hs_viol++;
    end
    if (bus.rf_we) rf_cnt++;
    if (bus.dmem_req_valid && !prq[3]) dreq_cnt++;
    if (bus.dmem_req_valid && bus.dmem_we) dwe_cnt++;
    if (bus.dec_req_valid && !prq[1]) dec_req_cnt++;
    for (int k = 0; k < 4; k++) begin
      rsp[k] = 1'b0;
      if (!rq[k]) begin
        cnt[k]  = 0;
        done[k] = 1'b0;
      end else if (!done[k]) begin
        if (cnt[k] >= dly[k]) begin
          rsp[k]  = 1'b1;
          done[k] = 1'b1;
        end else cnt[k]++;
      end
    end
    prq = rq;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1;
    repeat (3) step();
    if (check) begin
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_retired", bus.retired, 32'h0);
      chk("rst_trap", {31'b0, bus.trap}, 32'h0);
      chk("rst_reqs", {28'b0, rq}, 32'h0);
      chk("rst_strobes", {30'b0, bus.rf_we, bus.dmem_we}, 32'h0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 128; k++) begin
      mem[k] = 32'h0000_0013;
      tk_mem[k] = 1'b0;
      tg_mem[k] = 32'h0;
    end
  endtask

  // Instruction ends when the next fetch request rises or the core traps.
  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (bus.imem_req_valid && n < 300) begin step(); n++; end
    while (!bus.imem_req_valid && !bus.trap && n < 300) begin step(); n++; end
    ok = (n < 300);
  endtask

  function automatic vec_t mk(logic [31:0] pc, logic [31:0] instr, logic tk, logic [31:0] tgt,
                              logic [31:0] epc, logic [31:0] eret, int erf, int edreq,
                              logic edwe, logic etrap);
    vec_t v;
    v.pc = pc; v.instr = instr; v.tk = tk; v.tgt = tgt;
    v.exp_pc = epc; v.exp_ret = eret; v.exp_rf = erf; v.exp_dreq = edreq;
    v.exp_dwe = edwe; v.exp_trap = etrap;
    return v;
  endfunction

  initial begin
    bit ok;
    int rf0, dq0, dw0, hv0, dr0, n;
    vec_t e;

    vt[0] = mk(32'h00,  32'h003100B3, 0, 32'h0,   32'h04,  1, 1, 0, 0, 0); // ADD
    vt[1] = mk(32'h04,  32'h00112023, 0, 32'h0,   32'h08,  2, 0, 1, 1, 0); // SW
    vt[2] = mk(32'h08,  32'h00208C63, 1, 32'h20,  32'h20,  3, 0, 0, 0, 0); // BEQ taken
    vt[3] = mk(32'h20,  32'h00208C63, 0, 32'h40,  32'h24,  4, 0, 0, 0, 0); // BEQ not taken
    vt[4] = mk(32'h24,  32'h00012083, 0, 32'h0,   32'h28,  5, 1, 1, 0, 0); // LW
    vt[5] = mk(32'h28,  32'h000010B7, 0, 32'h0,   32'h2C,  6, 1, 0, 0, 0); // LUI
    vt[6] = mk(32'h2C,  32'h000080E7, 0, 32'h105, 32'h104, 7, 1, 0, 0, 0); // JALR
    vt[7] = mk(32'h104, 32'h008000EF, 0, 32'h102, 32'h104, 7, 1, 0, 0, 1); // JAL misaligned

    // Table run, all responders answer in one cycle.
    for (int k = 0; k < 4; k++) dly[k] = 0;
    clear_mem();
    foreach (vt[i]) begin
      mem[vt[i].pc[8:2]]    = vt[i].instr;
      tk_mem[vt[i].pc[8:2]] = vt[i].tk;
      tg_mem[vt[i].pc[8:2]] = vt[i].tgt;
    end
    do_reset(1);
    foreach (vt[i]) begin
      sbq.push_back(vt[i]);
      rf0 = rf_cnt; dq0 = dreq_cnt; dw0 = dwe_cnt;
      wait_done(ok);
      if (!ok) chk("done_timeout", 32'h0, 32'h1);
      e = sbq.pop_front();
      chk($sformatf("v%0d_pc", i), bus.pc, e.exp_pc);
      chk($sformatf("v%0d_retired", i), bus.retired, e.exp_ret);
      chk($sformatf("v%0d_rf_we", i), 32'(rf_cnt - rf0), 32'(e.exp_rf));
      chk($sformatf("v%0d_dmem_req", i), 32'(dreq_cnt - dq0), 32'(e.exp_dreq));
      chk($sformatf("v%0d_dmem_we", i), {31'b0, dwe_cnt != dw0}, {31'b0, e.exp_dwe});
      chk($sformatf("v%0d_trap", i), {31'b0, bus.trap}, {31'b0, e.exp_trap});
    end
    chk("trap_reqs_low", {28'b0, rq}, 32'h0);

    // Slow decoder, then an unknown opcode.
    clear_mem();
    mem[0] = 32'h003100B3;
    mem[1] = 32'h003100B3;
    mem[2] = 32'h0000007F;
    dly[1] = 4;
    do_reset(0);
    hv0 = hs_viol; dr0 = dec_req_cnt;
    n = 0;
    while (!bus.trap && n < 400) begin step(); n++; end
    chk("dec_wait", {31'b0, n < 400}, 32'h1);
    chk("dec_handshake_viol", 32'(hs_viol - hv0), 32'h0);
    chk("dec_req_count", 32'(dec_req_cnt - dr0), 32'h3);
    chk("badop_trap", {31'b0, bus.trap}, 32'h1);
    chk("badop_pc", bus.pc, 32'h8);
    chk("badop_retired", bus.retired, 32'h2);
    repeat (3) step();
    chk("trap_sticky", {31'b0, bus.trap}, 32'h1);

    // Instruction memory never answers: watchdog trips.
    dly[1] = 0;
    dly[0] = 100000;
    do_reset(0);
    repeat (30) step();
    chk("stall_early_trap", {31'b0, bus.trap}, 32'h0);
    repeat (60) step();
    chk("stall_trap", {31'b0, bus.trap}, 32'h1);
    chk("stall_pc", bus.pc, 32'h0);
    chk("stall_imem_req", {31'b0, bus.imem_req_valid}, 32'h0);

    // Reset while a fetch is outstanding.
    dly[0] = 0;
    do_reset(0);
    wait_done(ok);
    chk("pre_rst_pc", bus.pc, 32'h4);
    chk("pre_rst_retired", bus.retired, 32'h1);
    dly[0] = 100000;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_imem_req", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("midrst_pc", bus.pc, 32'h0);
    chk("midrst_retired", bus.retired, 32'h0);
    dly[0] = 0;
    step();
    rst = 1'b0;
    step();
    wait_done(ok);
    chk("post_rst_pc", bus.pc, 32'h4);
    chk("post_rst_retired", bus.retired, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the core; owns the PC and the instruction register.
- Steps each instruction through fetch, decode, execute, memory and writeback by driving req_valid/resp_valid handshakes to the instruction memory, the instruction decoder, the ALU and the data memory.
- Chooses the per-instruction state path from the decoded opcode and asserts the register-file write strobe.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TIMEOUT_CYCLES, 64: maximum cycles any request waits for resp_valid before trapping; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pc  out  32  current PC; also drives the imem address.
- imem_req_valid  out  1  fetch request.
- imem_resp_valid  in  1  fetch done, one-cycle pulse.
- imem_rdata  in  32  fetched word, valid with imem_resp_valid.
- instr  out  32  instruction register; feeds the decoder instruction input and the datapath.
- dec_req_valid  out  1  decode request.
- dec_resp_valid  in  1  decode done, pulse.
- dec_opcode  in  7  opcode_t from the decoder.
- alu_req_valid  out  1  execute request.
- alu_resp_valid  in  1  execute done, pulse.
- branch_taken  in  1  datapath compare result, valid with alu_resp_valid.
- target_addr  in  32  datapath jump/branch target, valid with alu_resp_valid.
- dmem_req_valid  out  1  memory request.
- dmem_we  out  1  1 for a store, 0 for a load; valid while dmem_req_valid is high.
- dmem_resp_valid  in  1  memory done, pulse.
- rf_we  out  1  register-file write strobe, one cycle.
- trap  out  1  sticky fault flag.
- retired  out  32  count of retired instructions.

Behaviour:
- Reset (async, rst=1): state=S_FETCH, pc=RESET_PC, instr=0, retired=0, trap=0, all req_valid=0, dmem_we=0, rf_we=0.
- The first imem_req_valid rises on the first clock edge after rst deasserts.
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP. All outputs are registered.
- Handshake, common to all four requesters:
  - req_valid is set on state entry and held high until the cycle after resp_valid is sampled high.
  - req_valid then drops for at least one cycle before any new request, because the decoder restarts its delay count only while req_valid is low.
  - resp_valid seen while the matching req_valid is low is ignored.
- S_FETCH: on imem_resp_valid, instr<=imem_rdata, go to S_DECODE.
- S_DECODE: on dec_resp_valid, branch on dec_opcode:
  - LUI goes to S_WB.
  - R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JAL, JALR, AUIPC go to S_EXEC.
  - Any other opcode goes to S_TRAP.
- S_EXEC: on alu_resp_valid:
  - LOAD or STORE goes to S_MEM; dmem_we=1 for STORE.
  - BRANCH completes the instruction.
  - All others go to S_WB.
  - target_addr and branch_taken are captured into internal registers in this cycle.
- S_MEM: on dmem_resp_valid, LOAD goes to S_WB; STORE completes.
- S_WB: rf_we=1 for exactly one cycle, then the instruction completes.
- Completion, in the same cycle the state returns to S_FETCH:
  - Next PC is target if JAL, JALR, or (BRANCH and taken); otherwise pc+4, with 32-bit wrap.
  - For JALR, target bit 0 is forced to 0.
  - If next-PC bit 1 = 1 (misaligned), go to S_TRAP instead; pc and retired are unchanged.
  - Otherwise retired<=retired+1, wrapping at 2^32.
- Minimum latencies with zero-latency responders are register-fixed; e.g. R-type = 4 state visits.
- Timeout:
  - A cycle counter clears on each state entry and increments while a request is outstanding.
  - Reaching TIMEOUT_CYCLES goes to S_TRAP.
- S_TRAP: trap=1, all requests deasserted, pc frozen. Only rst exits this state.
- rst asserted mid-handshake: all requests drop immediately (async); any late resp_valid after reset is ignored by rule.

Decomposition:
- Shared package _riscv_defines gets ctrl_state_t (the six-state enum) and the existing opcode_t/DATA_WIDTH.
- One natural sub-module: core_seq_timeout, the request watchdog counter with a clear input and an expired output.

Test Plan:
- ADD (instr 32'h003100B3), all responders 1-cycle:
  - pc 0 -> 4.
  - rf_we pulses once.
  - retired = 1.
  - dmem_req_valid never asserts.
- SW then LW:
  - SW gives dmem_we=1 and no rf_we.
  - LW gives dmem_we=0, then rf_we.
  - pc advances by 4 each; retired = 2.
- BEQ at pc 8, target 32'h20:
  - taken=1 -> pc 32'h20.
  - taken=0 -> pc 12.
  - rf_we stays 0 in both cases.
- JALR with target_addr 32'h0000_0105 -> pc 32'h104.
- JAL with target 32'h0000_0102 -> trap=1, pc unchanged, retired unchanged.
- Decoder with 4-cycle delay, and opcode 7'h7F:
  - dec_req_valid is held until dec_resp_valid and drops for at least one cycle between instructions.
  - Opcode 7'h7F gives trap=1.
  - Stalling imem for 64 cycles gives trap=1.
  - rst mid-fetch returns pc to RESET_PC and retired to 0.
